// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: access-size codes, port ids and
// the per-port response state.
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    LB_SB = 3'b000,
    LH_SH = 3'b001,
    LW_SW = 3'b010,
    LBU   = 3'b100,
    LHU   = 3'b101
  } mem_size_e;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_e;

  // Codes outside the enum fall through to the single-byte case.
  function automatic logic [2:0] size_bytes(mem_size_e size);
    case (size)
      LH_SH, LHU: return 3'd2;
      LW_SW:      return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check for one memory access: alignment, range and
// the protected address 0 for stores.
module dmem_access_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        we,
  output logic        fault,
  output logic        mem_wr_ok
);

  mem_size_e   size_e;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;
  logic        misaligned;
  logic        out_of_range;
  logic        zero_store;

  // Last byte is formed in 33 bits so an access near 2^32 cannot wrap into range.
  always_comb begin
    size_e       = mem_size_e'(size);
    nbytes       = size_bytes(size_e);
    last_byte    = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
    misaligned   = ((size_e == LH_SH || size_e == LHU) && addr[0])
                 || (size_e == LW_SW && addr[1:0] != 2'b00);
    out_of_range = last_byte >= 33'(MEM_BYTES);
    zero_store   = we && (addr == '0);
    fault        = misaligned | out_of_range | zero_store;
    mem_wr_ok    = we & ~fault;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: core LSU (C)
// and DMA/debug (D), one grant per cycle, one registered response per grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_size,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_rd_wr,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  port_e       rr_ptr;
  resp_state_e c_state;
  resp_state_e d_state;

  logic        contended;
  logic        c_wins;
  logic        grant;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_size;
  logic        sel_we;
  logic        fault;
  logic        wr_ok;
  logic [31:0] resp_data;

  always_comb begin
    contended = c_req & d_req;
    c_wins    = c_req & (~d_req | (FIXED_PRIO != 0) | (rr_ptr == PORT_C));
    c_gnt     = reset & c_wins;
    d_gnt     = reset & d_req & ~c_wins;
    grant     = c_gnt | d_gnt;
  end

  always_comb begin
    sel_addr  = d_gnt ? d_addr  : c_addr;
    sel_wdata = d_gnt ? d_wdata : c_wdata;
    sel_size  = d_gnt ? d_size  : c_size;
    sel_we    = d_gnt ? d_we    : c_we;
  end

  dmem_access_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr     (sel_addr),
    .size     (sel_size),
    .we       (sel_we),
    .fault    (fault),
    .mem_wr_ok(wr_ok)
  );

  always_comb begin
    if (grant) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_rd_wr = sel_size;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_rd_wr = LB_SB;
    end
    mem_wr    = grant & wr_ok;
    resp_data = (sel_we | fault) ? '0 : mem_rdata;
  end

  // Only contended grants rotate priority; the loser is favoured next time.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr <= PORT_C;
    end else if (contended && grant) begin
      rr_ptr <= c_gnt ? PORT_D : PORT_C;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      c_state <= IDLE;
      c_rdata <= '0;
      c_err   <= 1'b0;
    end else begin
      c_state <= c_gnt ? RESP : IDLE;
      c_rdata <= c_gnt ? resp_data : '0;
      c_err   <= c_gnt & fault;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      d_state <= IDLE;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      d_state <= d_gnt ? RESP : IDLE;
      d_rdata <= d_gnt ? resp_data : '0;
      d_err   <= d_gnt & fault;
    end
  end

  assign c_rvalid = (c_state == RESP);
  assign d_rvalid = (d_state == RESP);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a data-memory stand-in, a rule-level reference
// model checked every cycle, and directed scenarios with literal pins.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MB = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [2:0]  c_size, d_size;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_rd_wr;
  logic        mem_wr;

  logic        fx_c_req, fx_d_req;
  logic        fx_c_gnt, fx_d_gnt, fx_c_rvalid, fx_d_rvalid, fx_c_err, fx_d_err, fx_mem_wr;
  logic [31:0] fx_c_rdata, fx_d_rdata, fx_mem_addr, fx_mem_wdata;
  logic [2:0]  fx_mem_rd_wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.MEM_BYTES(MB), .FIXED_PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_size(c_size),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_wr(mem_rd_wr),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MEM_BYTES(MB), .FIXED_PRIO(1)) dut_fx (
    .clock(clock), .reset(reset),
    .c_req(fx_c_req), .c_we(1'b0), .c_addr(32'h4), .c_wdata(32'h0), .c_size(3'b010),
    .c_gnt(fx_c_gnt), .c_rvalid(fx_c_rvalid), .c_rdata(fx_c_rdata), .c_err(fx_c_err),
    .d_req(fx_d_req), .d_we(1'b0), .d_addr(32'h8), .d_wdata(32'h0), .d_size(3'b010),
    .d_gnt(fx_d_gnt), .d_rvalid(fx_d_rvalid), .d_rdata(fx_d_rdata), .d_err(fx_d_err),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_rd_wr(fx_mem_rd_wr),
    .mem_wr(fx_mem_wr), .mem_rdata(32'h0)
  );

  function automatic int nbytes(input logic [2:0] code);
    if (code == 3'b001 || code == 3'b101) return 2;
    if (code == 3'b010) return 4;
    return 1;
  endfunction

  // data_memory stand-in: negedge store, combinational extended read
  logic [7:0] phys [MB] = '{default: 8'h00};
  int         ra;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] code);
    case (code)
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b010:  return raw;
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return {{24{raw[7]}}, raw[7:0]};
    endcase
  endfunction

  always @(negedge clock)
    if (mem_wr === 1'b1)
      for (int i = 0; i < nbytes(mem_rd_wr); i++)
        phys[(int'(mem_addr[4:0]) + i) % MB] <= mem_wdata[8*i +: 8];

  always_comb begin
    ra        = int'(mem_addr[4:0]);
    mem_rdata = extend({phys[(ra+3)%MB], phys[(ra+2)%MB], phys[(ra+1)%MB], phys[ra]}, mem_rd_wr);
  end

  // reference model
  logic [7:0] ref_mem [MB] = '{default: 8'h00};

  function automatic bit model_fault(input logic [31:0] addr, input logic [2:0] code, input logic we);
    int n;
    n = nbytes(code);
    if ((addr % 32'(n)) != 0) return 1'b1;
    if (longint'({32'd0, addr}) + longint'(n) > longint'(MB)) return 1'b1;
    if (we && addr == 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] code);
    longint v;
    int     n;
    v = 0;
    n = nbytes(code);
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[int'((addr + 32'(i)) % 32'(MB))]) << (8 * i);
    if (code != 3'b100 && code != 3'b101 && v >= (longint'(1) << (8*n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Directed literal pins are captured by the stimulus and judged by the compare process.
  string       pin_name [128];
  logic [31:0] pin_act  [128];
  logic [31:0] pin_exp  [128];
  int          pin_wr = 0;
  int          pin_rd = 0;

  task automatic pin(input string n, input logic [31:0] a, input logic [31:0] e);
    pin_name[pin_wr] = n;
    pin_act[pin_wr]  = a;
    pin_exp[pin_wr]  = e;
    pin_wr++;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  bit          model_on = 1'b0;
  bit          favour_d, pend_favour;
  logic        exp_c_v, exp_c_e, exp_d_v, exp_d_e;
  logic [31:0] exp_c_d, exp_d_d;
  logic        pnd_c_v, pnd_c_e, pnd_d_v, pnd_d_e;
  logic [31:0] pnd_c_d, pnd_d_d;
  logic        want_c, want_d, gr, m_we, m_f;
  logic [31:0] m_a, m_wd;
  logic [2:0]  m_code;

  always @(posedge clock) begin
    if (!reset) begin
      {exp_c_v, exp_c_e, exp_d_v, exp_d_e} = '0;
      exp_c_d  = '0;
      exp_d_d  = '0;
      favour_d = 1'b0;
      model_on = 1'b1;
    end else begin
      {exp_c_v, exp_c_e, exp_c_d} = {pnd_c_v, pnd_c_e, pnd_c_d};
      {exp_d_v, exp_d_e, exp_d_d} = {pnd_d_v, pnd_d_e, pnd_d_d};
      favour_d = pend_favour;
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("c_rvalid", 32'(c_rvalid), 32'(exp_c_v));
      chk("c_err",    32'(c_err),    32'(exp_c_e));
      chk("c_rdata",  c_rdata,       exp_c_d);
      chk("d_rvalid", 32'(d_rvalid), 32'(exp_d_v));
      chk("d_err",    32'(d_err),    32'(exp_d_e));
      chk("d_rdata",  d_rdata,       exp_d_d);

      want_c = reset && c_req && (!d_req || !favour_d);
      want_d = reset && d_req && (!c_req || favour_d);
      gr     = want_c || want_d;
      m_a    = want_d ? d_addr  : c_addr;
      m_wd   = want_d ? d_wdata : c_wdata;
      m_code = want_d ? d_size  : c_size;
      m_we   = want_d ? d_we    : c_we;
      m_f    = model_fault(m_a, m_code, m_we);

      chk("c_gnt",     32'(c_gnt),     32'(want_c));
      chk("d_gnt",     32'(d_gnt),     32'(want_d));
      chk("mem_addr",  mem_addr,       gr ? m_a : 32'd0);
      chk("mem_rd_wr", 32'(mem_rd_wr), gr ? 32'(m_code) : 32'd0);
      chk("mem_wr",    32'(mem_wr),    32'(gr && m_we && !m_f));
      if (gr && m_we) chk("mem_wdata", mem_wdata, m_wd);

      pnd_c_v = want_c;
      pnd_c_e = want_c && m_f;
      pnd_c_d = (want_c && !m_we && !m_f) ? model_load(m_a, m_code) : 32'd0;
      pnd_d_v = want_d;
      pnd_d_e = want_d && m_f;
      pnd_d_d = (want_d && !m_we && !m_f) ? model_load(m_a, m_code) : 32'd0;
      pend_favour = (c_req && d_req && gr) ? want_c : favour_d;

      if (gr && m_we && !m_f)
        for (int i = 0; i < nbytes(m_code); i++)
          ref_mem[int'((m_a + 32'(i)) % 32'(MB))] = m_wd[8*i +: 8];

      while (pin_rd < pin_wr) begin
        chk(pin_name[pin_rd], pin_act[pin_rd], pin_exp[pin_rd]);
        pin_rd++;
      end
    end
  end

  // Holds one request until granted (bounded), returns #1 into the response cycle.
  task automatic issue(input bit on_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] size);
    bit got;
    got = 1'b0;
    if (on_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; c_size = size;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clock);
      got = on_d ? d_gnt : c_gnt;
      @(posedge clock); #1;
    end
    if (on_d) d_req = 1'b0; else c_req = 1'b0;
    pin(on_d ? "d_gnt_wait" : "c_gnt_wait", 32'(got), 32'd1);
  endtask

  task automatic resp(input bit on_d, input logic [31:0] data, input logic err);
    pin(on_d ? "d_rvalid_pin" : "c_rvalid_pin", 32'(on_d ? d_rvalid : c_rvalid), 32'd1);
    pin(on_d ? "d_rdata_pin"  : "c_rdata_pin",  on_d ? d_rdata : c_rdata, data);
    pin(on_d ? "d_err_pin"    : "c_err_pin",    32'(on_d ? d_err : c_err), 32'(err));
    pin(on_d ? "c_quiet_pin"  : "d_quiet_pin",  32'(on_d ? c_rvalid : d_rvalid), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    {c_req, c_we, d_req, d_we, fx_c_req, fx_d_req} = '0;
    {c_addr, c_wdata, d_addr, d_wdata} = '0;
    c_size = 3'b000;
    d_size = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    pin("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    pin("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    pin("rst_c_rdata",  c_rdata, 32'd0);
    pin("rst_d_err",    32'(d_err), 32'd0);
    reset = 1'b1;

    issue(0, 1, 32'h4, 32'h1122_3344, 3'b010); resp(0, 32'h0, 1'b0);
    issue(0, 0, 32'h4, 32'h0, 3'b010);         resp(0, 32'h1122_3344, 1'b0);

    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h4; c_size = 3'b010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_size = 3'b010;
    fx_c_req = 1'b1; fx_d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      pin("rr_c_gnt", 32'(c_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      pin("rr_d_gnt", 32'(d_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      pin("fx_c_gnt", 32'(fx_c_gnt), 32'd1);
      pin("fx_d_gnt", 32'(fx_d_gnt), 32'd0);
      @(posedge clock); #1;
    end
    c_req = 1'b0; d_req = 1'b0; fx_c_req = 1'b0;
    @(negedge clock);
    pin("fx_d_after", 32'(fx_d_gnt), 32'd1);
    @(posedge clock); #1;
    fx_d_req = 1'b0;
    pin("fx_d_rvalid", 32'(fx_d_rvalid), 32'd1);
    pin("fx_c_rvalid", 32'(fx_c_rvalid), 32'd0);

    issue(0, 1, 32'h6, 32'hDEAD_BEEF, 3'b010); resp(0, 32'h0, 1'b1);
    issue(1, 1, 32'h3, 32'h0000_BEEF, 3'b001); resp(1, 32'h0, 1'b1);
    issue(1, 0, 32'h3, 32'h0, 3'b001);         resp(1, 32'h0, 1'b1);
    issue(0, 0, 32'h6, 32'h0, 3'b010);         resp(0, 32'h0, 1'b1);
    issue(0, 0, 32'h4, 32'h0, 3'b010);         resp(0, 32'h1122_3344, 1'b0);

    issue(0, 0, 32'h1E, 32'h0, 3'b010);        resp(0, 32'h0, 1'b1);
    issue(1, 1, 32'h0, 32'h77, 3'b000);        resp(1, 32'h0, 1'b1);
    issue(0, 1, 32'h1F, 32'hA5, 3'b000);       resp(0, 32'h0, 1'b0);
    issue(0, 0, 32'h1F, 32'h0, 3'b100);        resp(0, 32'h0000_00A5, 1'b0);
    issue(1, 0, 32'h1F, 32'h0, 3'b000);        resp(1, 32'hFFFF_FFA5, 1'b0);
    issue(0, 0, 32'h1E, 32'h0, 3'b101);        resp(0, 32'h0000_A500, 1'b0);
    issue(0, 0, 32'h1C, 32'h0, 3'b010);        resp(0, 32'hA500_0000, 1'b0);

    issue(1, 1, 32'h8, 32'h0000_00FF, 3'b000);
    pin("mid_d_rvalid", 32'(d_rvalid), 32'd1);
    reset = 1'b0;
    @(posedge clock); #1;
    pin("mid_d_dropped", 32'(d_rvalid), 32'd0);
    reset = 1'b1;
    issue(0, 0, 32'h8, 32'h0, 3'b100);         resp(0, 32'h0000_00FF, 1'b0);

    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h4; c_size = 3'b010;
    @(negedge clock);
    pin("late_c_gnt", 32'(c_gnt), 32'd1);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    pin("late_c_rvalid0", 32'(c_rvalid), 32'd0);
    @(posedge clock); #1;
    c_req = 1'b0;
    reset = 1'b1;
    pin("late_c_rvalid1", 32'(c_rvalid), 32'd0);
    @(posedge clock); #1;
    pin("late_c_rvalid2", 32'(c_rvalid), 32'd0);

    repeat (3) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
